// File: rtl/gtfmac_vnc_rate_count_pkg.sv
// Shared types and helpers for the multi-channel rate counter.
// Optional min/max tracking is enabled by defining GTFMAC_VNC_RATE_COUNT_MINMAX_EN.
package gtfmac_vnc_rate_count_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Adds inc to val, holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic        inc,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    if (inc && (val != max_val)) begin
      return val + 64'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/gtfmac_vnc_rate_count_ch.sv
// One event channel: saturating live counter, snapshot, sticky overflow.
// Min/max snapshot tracking exists only with GTFMAC_VNC_RATE_COUNT_MINMAX_EN.
module gtfmac_vnc_rate_count_ch
  import gtfmac_vnc_rate_count_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             event_in,
  input  logic             run,
  input  logic             boundary,
  input  logic             clear,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow_out
`ifdef GTFMAC_VNC_RATE_COUNT_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_out,
  output logic [CNT_W-1:0] max_out
`endif
);

  logic [CNT_W-1:0] live_q, live_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] inc_val;
  logic             sat_hit;

  always_comb begin
    inc_val = CNT_W'(sat_inc(64'(live_q), event_in, CNT_W));
    sat_hit = event_in & (&live_q);
    live_d  = live_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q;
    if (clear) begin
      live_d = '0;
      ovf_d  = 1'b0;
    end else if (!run) begin
      live_d = '0;
    end else begin
      if (sat_hit) begin
        ovf_d = 1'b1;
      end
      // The boundary cycle's own event is folded into the snapshot.
      if (boundary) begin
        snap_d = inc_val;
        live_d = '0;
      end else begin
        live_d = inc_val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      live_q <= live_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign count_out    = snap_q;
  assign overflow_out = ovf_q;

`ifdef GTFMAC_VNC_RATE_COUNT_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear) begin
      min_d = '1;
      max_d = '0;
    end else if (run && boundary) begin
      if (inc_val < min_q) begin
        min_d = inc_val;
      end
      if (inc_val > max_q) begin
        max_d = inc_val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_out = min_q;
  assign max_out = max_q;
`endif

endmodule

// File: rtl/gtfmac_vnc_rate_count_multi.sv
// Multi-channel event rate counter windowed by an async one-second toggle.
// Defining GTFMAC_VNC_RATE_COUNT_MINMAX_EN adds min_out/max_out per channel.
module gtfmac_vnc_rate_count_multi
  import gtfmac_vnc_rate_count_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int WINDOW_EDGES = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    one_second_edge,
  input  logic [NUM_CH-1:0]       event_in,
  input  logic                    clear,
  output logic [NUM_CH*CNT_W-1:0] counts_out,
  output logic                    snap_valid,
  output logic                    snap_stb,
  output logic [NUM_CH-1:0]       overflow
`ifdef GTFMAC_VNC_RATE_COUNT_MINMAX_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] min_out,
  output logic [NUM_CH*CNT_W-1:0] max_out
`endif
);

  localparam int EC_W = (WINDOW_EDGES > 1) ? $clog2(WINDOW_EDGES) : 1;
  localparam logic [EC_W-1:0] EC_LAST = EC_W'(WINDOW_EDGES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_d_q;
  logic                   detect;
  state_e                 state_q, state_d;
  logic [EC_W-1:0]        edge_cnt_q, edge_cnt_d;
  logic                   snap_valid_q, snap_valid_d;
  logic                   snap_stb_q, snap_stb_d;
  logic                   boundary;
  logic                   run;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], one_second_edge};
  // Either polarity of the reference marks a tick.
  assign detect = sync_q[SYNC_STAGES-1] ^ edge_d_q;
  assign run    = (state_q == ST_RUN);

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    snap_valid_d = snap_valid_q;
    snap_stb_d   = 1'b0;
    boundary     = 1'b0;
    if (clear) begin
      state_d      = ST_IDLE;
      edge_cnt_d   = '0;
      snap_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (detect) begin
            edge_cnt_d = '0;
            state_d    = ST_RUN;
          end
        end
        ST_RUN: begin
          if (detect) begin
            if (edge_cnt_q == EC_LAST) begin
              boundary     = 1'b1;
              edge_cnt_d   = '0;
              snap_stb_d   = 1'b1;
              snap_valid_d = 1'b1;
            end else begin
              edge_cnt_d = EC_W'(edge_cnt_q + 1'b1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      edge_d_q     <= 1'b0;
      state_q      <= ST_IDLE;
      edge_cnt_q   <= '0;
      snap_valid_q <= 1'b0;
      snap_stb_q   <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      edge_d_q     <= sync_q[SYNC_STAGES-1];
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      snap_valid_q <= snap_valid_d;
      snap_stb_q   <= snap_stb_d;
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_stb   = snap_stb_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      gtfmac_vnc_rate_count_ch #(
        .CNT_W(CNT_W)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .event_in    (event_in[gi]),
        .run         (run),
        .boundary    (boundary),
        .clear       (clear),
        .count_out   (counts_out[gi*CNT_W +: CNT_W]),
        .overflow_out(overflow[gi])
`ifdef GTFMAC_VNC_RATE_COUNT_MINMAX_EN
        ,
        .min_out     (min_out[gi*CNT_W +: CNT_W]),
        .max_out     (max_out[gi*CNT_W +: CNT_W])
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_gtfmac_vnc_rate_count_multi.sv
// Directed bench for gtfmac_vnc_rate_count_multi over three parameter sets.
// Min/max checks are built when GTFMAC_VNC_RATE_COUNT_MINMAX_EN is defined.
module tb_gtfmac_vnc_rate_count_multi;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ref_lvl = 1'b0;
  logic clear = 1'b0;
  logic [1:0] ev_a = 2'b11;
  logic [1:0] ev_b = 2'b10;
  logic [1:0] ev_c = 2'b01;

  logic [63:0] counts_a, counts_b;
  logic [15:0] counts_c;
  logic valid_a, valid_b, valid_c;
  logic stb_a, stb_b, stb_c;
  logic [1:0] ovf_a, ovf_b, ovf_c;
`ifdef GTFMAC_VNC_RATE_COUNT_MINMAX_EN
  logic [63:0] min_a, max_a, min_b, max_b;
  logic [15:0] min_c, max_c;
`endif

  int checks = 0;
  int errors = 0;
  int stb_cnt_a = 0;
  int stb_cnt_b = 0;
  int stb_cnt_c = 0;

  always #5 clk = ~clk;

  gtfmac_vnc_rate_count_multi #(.NUM_CH(2), .CNT_W(32), .WINDOW_EDGES(1), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset(reset), .one_second_edge(ref_lvl), .event_in(ev_a), .clear(clear),
    .counts_out(counts_a), .snap_valid(valid_a), .snap_stb(stb_a), .overflow(ovf_a)
`ifdef GTFMAC_VNC_RATE_COUNT_MINMAX_EN
    , .min_out(min_a), .max_out(max_a)
`endif
  );

  gtfmac_vnc_rate_count_multi #(.NUM_CH(2), .CNT_W(32), .WINDOW_EDGES(4), .SYNC_STAGES(2)) u_b (
    .clk(clk), .reset(reset), .one_second_edge(ref_lvl), .event_in(ev_b), .clear(clear),
    .counts_out(counts_b), .snap_valid(valid_b), .snap_stb(stb_b), .overflow(ovf_b)
`ifdef GTFMAC_VNC_RATE_COUNT_MINMAX_EN
    , .min_out(min_b), .max_out(max_b)
`endif
  );

  gtfmac_vnc_rate_count_multi #(.NUM_CH(2), .CNT_W(8), .WINDOW_EDGES(1), .SYNC_STAGES(2)) u_c (
    .clk(clk), .reset(reset), .one_second_edge(ref_lvl), .event_in(ev_c), .clear(clear),
    .counts_out(counts_c), .snap_valid(valid_c), .snap_stb(stb_c), .overflow(ovf_c)
`ifdef GTFMAC_VNC_RATE_COUNT_MINMAX_EN
    , .min_out(min_c), .max_out(max_c)
`endif
  );

  typedef struct {
    int          period;
    int          ntog;
    logic [63:0] exp_a;
    int          stb_a;
    logic [63:0] exp_b;
    int          stb_b;
    logic [15:0] exp_c;
    int          stb_c;
    logic [1:0]  ovf_c;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge, B channel 0 strobes every other cycle.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ev_b[0] = ~ev_b[0];
      if (stb_a) stb_cnt_a++;
      if (stb_b) stb_cnt_b++;
      if (stb_c) stb_cnt_c++;
    end
  endtask

  task automatic clr_stb();
    stb_cnt_a = 0;
    stb_cnt_b = 0;
    stb_cnt_c = 0;
  endtask

  task automatic do_reset();
    ref_lvl = 1'b0;
    clear   = 1'b0;
    reset   = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    clr_stb();
  endtask

  task automatic toggle();
    ref_lvl = ~ref_lvl;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1000, 3, {32'd1000, 32'd1000}, 2, 64'd0, 0, {8'd0, 8'd255}, 2, 2'b01};
    vecs[1] = '{250, 9, {32'd250, 32'd250}, 8, {32'd1000, 32'd500}, 2, {8'd0, 8'd250}, 8, 2'b00};
    vecs[2] = '{300, 3, {32'd300, 32'd300}, 2, 64'd0, 0, {8'd0, 8'd255}, 2, 2'b01};
    vecs[3] = '{200, 2, {32'd200, 32'd200}, 1, 64'd0, 0, {8'd0, 8'd200}, 1, 2'b00};

    for (int v = 0; v < 4; v++) begin
      do_reset();
      chk("rst_counts_a", counts_a, 64'd0);
      chk("rst_valid_a", {63'd0, valid_a}, 64'd0);
      chk("rst_stb_a", {63'd0, stb_a}, 64'd0);
      chk("rst_ovf_c", {62'd0, ovf_c}, 64'd0);
      for (int k = 0; k < vecs[v].ntog; k++) begin
        toggle();
        tick((k < vecs[v].ntog - 1) ? vecs[v].period : 20);
      end
      chk("counts_a", counts_a, vecs[v].exp_a);
      chk("stb_a", 64'(stb_cnt_a), 64'(vecs[v].stb_a));
      chk("valid_a", {63'd0, valid_a}, {63'd0, vecs[v].stb_a > 0});
      chk("ovf_a", {62'd0, ovf_a}, 64'd0);
      chk("counts_b", counts_b, vecs[v].exp_b);
      chk("stb_b", 64'(stb_cnt_b), 64'(vecs[v].stb_b));
      chk("valid_b", {63'd0, valid_b}, {63'd0, vecs[v].stb_b > 0});
      chk("counts_c", {48'd0, counts_c}, {48'd0, vecs[v].exp_c});
      chk("stb_c", 64'(stb_cnt_c), 64'(vecs[v].stb_c));
      chk("ovf_c", {62'd0, ovf_c}, {62'd0, vecs[v].ovf_c});
      $display("vec %0d period=%0d toggles=%0d a=%0d b0=%0d c=%0d stb=%0d/%0d/%0d", v,
               vecs[v].period, vecs[v].ntog, counts_a[31:0], counts_b[31:0], counts_c[7:0],
               stb_cnt_a, stb_cnt_b, stb_cnt_c);
    end

    // Clear landing on the exact boundary cycle.
    do_reset();
    toggle(); tick(1000);
    toggle(); tick(500);
    clr_stb();
    toggle(); tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(397);
    chk("clrb_stb", 64'(stb_cnt_a), 64'd0);
    chk("clrb_counts", counts_a, {32'd1000, 32'd1000});
    chk("clrb_valid", {63'd0, valid_a}, 64'd0);
    toggle(); tick(400);
    chk("clrb_first_tog_stb", 64'(stb_cnt_a), 64'd0);
    chk("clrb_first_tog_counts", counts_a, {32'd1000, 32'd1000});
    toggle(); tick(20);
    chk("clrb_resume_stb", 64'(stb_cnt_a), 64'd1);
    chk("clrb_resume_counts", counts_a, {32'd400, 32'd400});
    chk("clrb_resume_valid", {63'd0, valid_a}, 64'd1);
    $display("clear-on-boundary seq counts_a=%0d stb=%0d", counts_a[31:0], stb_cnt_a);

    // Sticky overflow across a non-saturating window, then clear.
    do_reset();
    toggle(); tick(300);
    toggle(); tick(100);
    toggle(); tick(20);
    chk("sticky_counts_c", {48'd0, counts_c}, {48'd0, 8'd0, 8'd100});
    chk("sticky_ovf_c", {62'd0, ovf_c}, {62'd0, 2'b01});
    chk("sticky_valid_c", {63'd0, valid_c}, 64'd1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    chk("clr_ovf_c", {62'd0, ovf_c}, 64'd0);
    chk("clr_valid_c", {63'd0, valid_c}, 64'd0);
    chk("clr_keep_counts_c", {48'd0, counts_c}, {48'd0, 8'd0, 8'd100});
    $display("overflow seq counts_c=%0d ovf_c=%b", counts_c[7:0], ovf_c);

    // Asynchronous reset mid-window.
    do_reset();
    toggle(); tick(1000);
    toggle(); tick(500);
    chk("pre_rst_counts_a", counts_a, {32'd1000, 32'd1000});
    #3;
    reset   = 1'b1;
    ref_lvl = 1'b0;
    #1;
    chk("async_rst_counts_a", counts_a, 64'd0);
    chk("async_rst_valid_a", {63'd0, valid_a}, 64'd0);
    chk("async_rst_counts_c", {48'd0, counts_c}, 64'd0);
    tick(2);
    reset = 1'b0;
    tick(5);
    clr_stb();
    toggle(); tick(600);
    chk("post_rst_discard_stb", 64'(stb_cnt_a), 64'd0);
    toggle(); tick(20);
    chk("post_rst_stb", 64'(stb_cnt_a), 64'd1);
    chk("post_rst_counts_a", counts_a, {32'd600, 32'd600});
    $display("reset seq counts_a=%0d stb=%0d", counts_a[31:0], stb_cnt_a);

`ifdef GTFMAC_VNC_RATE_COUNT_MINMAX_EN
    do_reset();
    chk("rst_min_a", min_a, {64{1'b1}});
    chk("rst_max_a", max_a, 64'd0);
    chk("rst_min_b", min_b, {64{1'b1}});
    chk("rst_max_b", max_b, 64'd0);
    chk("rst_min_c", {48'd0, min_c}, {48'd0, 16'hffff});
    chk("rst_max_c", {48'd0, max_c}, 64'd0);
    toggle(); tick(900);
    toggle(); tick(1100);
    toggle(); tick(1000);
    toggle(); tick(20);
    chk("min_a", min_a, {32'd900, 32'd900});
    chk("max_a", max_a, {32'd1100, 32'd1100});
    chk("last_counts_a", counts_a, {32'd1000, 32'd1000});
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    chk("clr_min_a", min_a, {64{1'b1}});
    chk("clr_max_a", max_a, 64'd0);
    $display("minmax seq min_a=%0d max_a=%0d", min_a[31:0], max_a[31:0]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
